// File: rtl/square_calculator.sv
// Iterative shift-add squarer: o_square = i_root^2 after BW iterations, start/busy/finish handshake.
// Accept edge 0, result on edge BW, o_finish high the following cycle; i_start ignored while busy.
module square_calculator #(
  parameter int BW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [BW-1:0]   i_root,
  output logic            o_busy,
  output logic            o_finish,
  output logic [2*BW-1:0] o_square,
  output logic [50:0]     number
);

  localparam int W  = 2 * BW;
  localparam int CW = (BW < 2) ? 1 : $clog2(BW);

  // Primitive cost model: transistors per cell and cells used by this datapath/FSM.
  localparam int T_FD2    = 44;
  localparam int T_FA1    = 28;
  localparam int T_MUX21H = 12;
  localparam int T_IV     = 2;
  localparam int T_FSM    = 24;
  localparam int N_FD2    = W + BW + W + CW + W + 2 + 2;
  localparam int N_FA1    = W + CW;
  localparam int N_MUX21H = W + (W + BW + W + CW) + W;
  localparam int N_IV     = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q;
  logic [W-1:0]    opa_q;
  logic [BW-1:0]   mul_q;
  logic [W-1:0]    acc_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    square_q;
  logic            busy_q;
  logic            finish_q;

  logic [W-1:0]    addend_d;
  logic [W-1:0]    sum_d;

  // Partial product is opA gated by the current multiplier LSB; carry-out cannot occur.
  always_comb begin
    addend_d = mul_q[0] ? opa_q : '0;
    sum_d    = acc_q + addend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      mul_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      square_q <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          finish_q <= 1'b0;
          if (i_start) begin
            opa_q   <= {{BW{1'b0}}, i_root};
            mul_q   <= i_root;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          acc_q <= sum_d;
          opa_q <= opa_q << 1;
          mul_q <= mul_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(BW - 1)) begin
            square_q <= sum_d;
            state_q  <= DONE;
            finish_q <= 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          finish_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          finish_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_finish = finish_q;
  assign o_square = square_q;
  assign number   = 51'(N_FD2 * T_FD2 + N_FA1 * T_FA1 + N_MUX21H * T_MUX21H + N_IV * T_IV + T_FSM);

endmodule

// File: tb/tb_square_calculator.sv
// Directed bench for square_calculator (BW=5): latency, handshake, abort, exhaustive squares, cost output.
module tb_square_calculator;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [4:0]  i_root;
  logic        o_busy;
  logic        o_finish;
  logic [9:0]  o_square;
  logic [50:0] number;

  int n_checks;
  int n_fail;

  // 42 FD2*44 + 13 FA1*28 + 48 MUX21H*12 + 2 IV*2 + 24 FSM = 2816 for BW=5.
  localparam logic [50:0] EXP_NUMBER = 51'd2816;

  square_calculator #(.BW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_root   (i_root),
    .o_busy   (o_busy),
    .o_finish (o_finish),
    .o_square (o_square),
    .number   (number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  task automatic test_reset;
    rst = 1'b1; i_start = 1'b0; i_root = 5'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_checks++; if (o_finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got %b want 0", o_finish); end
    n_checks++; if (o_square !== 10'd0) begin n_fail++; $display("FAIL reset_square got %0d want 0", o_square); end
    n_checks++; if (number !== EXP_NUMBER) begin n_fail++; $display("FAIL reset_number got %0d want %0d", number, EXP_NUMBER); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (o_finish !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL release_idle got busy=%b finish=%b want 0 0", o_busy, o_finish); end
  endtask

  task automatic test_basic;
    logic [4:0] roots [4] = '{5'd31, 5'd0, 5'd1, 5'd16};
    logic [9:0] exps  [4] = '{10'd961, 10'd0, 10'd1, 10'd256};
    bit early;
    for (int k = 0; k < 4; k++) begin
      i_root = roots[k]; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      n_checks++; if (o_busy !== 1'b1 || o_finish !== 1'b0) begin n_fail++; $display("FAIL basic_c1 root=%0d got busy=%b finish=%b want 1 0", roots[k], o_busy, o_finish); end
      early = 1'b0;
      for (int c = 2; c <= 5; c++) begin
        @(negedge clk);
        if (o_finish !== 1'b0 || o_busy !== 1'b1) early = 1'b1;
      end
      n_checks++; if (early) begin n_fail++; $display("FAIL basic_c2to5 root=%0d got early finish/idle want busy no finish", roots[k]); end
      @(negedge clk);
      n_checks++; if (o_finish !== 1'b1 || o_square !== exps[k]) begin n_fail++; $display("FAIL basic_c6 root=%0d got finish=%b square=%0d want 1 %0d", roots[k], o_finish, o_square, exps[k]); end
      @(negedge clk);
      n_checks++; if (o_busy !== 1'b0 || o_finish !== 1'b0 || o_square !== exps[k]) begin n_fail++; $display("FAIL basic_c7 root=%0d got busy=%b finish=%b square=%0d want 0 0 %0d", roots[k], o_busy, o_finish, o_square, exps[k]); end
      @(negedge clk);
    end
  endtask

  task automatic test_held_start;
    int n_fin;
    int fin_cyc [2];
    logic [9:0] fin_sq [2];
    n_fin = 0;
    i_root = 5'd17; i_start = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (cyc == 2) i_root = 5'd3;
      if (cyc == 5) i_root = 5'd17;
      if (cyc == 10) i_start = 1'b0;
      if (o_finish === 1'b1) begin
        if (n_fin < 2) begin fin_cyc[n_fin] = cyc; fin_sq[n_fin] = o_square; end
        n_fin++;
      end
    end
    n_checks++; if (n_fin != 2) begin n_fail++; $display("FAIL held_count got %0d finishes want 2", n_fin); end
    if (n_fin >= 2) begin
      n_checks++; if (fin_cyc[0] != 6 || fin_cyc[1] != 13) begin n_fail++; $display("FAIL held_cycles got %0d,%0d want 6,13", fin_cyc[0], fin_cyc[1]); end
      n_checks++; if (fin_sq[0] !== 10'd289 || fin_sq[1] !== 10'd289) begin n_fail++; $display("FAIL held_square got %0d,%0d want 289,289", fin_sq[0], fin_sq[1]); end
    end
  endtask

  task automatic test_abort;
    bit spurious;
    int cyc;
    i_root = 5'd25; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o_busy !== 1'b0 || o_finish !== 1'b0 || o_square !== 10'd0) begin n_fail++; $display("FAIL abort_immediate got busy=%b finish=%b square=%0d want 0 0 0", o_busy, o_finish, o_square); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_finish !== 1'b0 || o_busy !== 1'b0) spurious = 1'b1;
    end
    n_checks++; if (spurious) begin n_fail++; $display("FAIL abort_quiet got activity after abort want none"); end
    i_root = 5'd9; i_start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
    end while (o_finish !== 1'b1 && cyc < 20);
    n_checks++; if (cyc != 6 || o_square !== 10'd81) begin n_fail++; $display("FAIL abort_restart got cycle=%0d square=%0d want 6 81", cyc, o_square); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int gap;
    int sq;
    i_root = 5'd0; i_start = 1'b1;
    for (int r = 0; r < 32; r++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (o_finish !== 1'b1 && gap < 20);
      if (r < 31) i_root = 5'(r + 1);
      else i_start = 1'b0;
      n_checks++; if (gap != ((r == 0) ? 6 : 7)) begin n_fail++; $display("FAIL b2b_gap root=%0d got %0d want %0d", r, gap, (r == 0) ? 6 : 7); end
      n_checks++; if (o_square !== 10'(r * r)) begin n_fail++; $display("FAIL b2b_square root=%0d got %0d want %0d", r, o_square, r * r); end
      sq = int'(o_square);
      n_checks++; if (isqrt(sq) != r) begin n_fail++; $display("FAIL b2b_sqrt root=%0d got %0d want %0d", r, isqrt(sq), r); end
      if (r > 0) begin
        n_checks++; if (isqrt(sq - 1) != r - 1) begin n_fail++; $display("FAIL b2b_sqrt_m1 root=%0d got %0d want %0d", r, isqrt(sq - 1), r - 1); end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_number;
    n_checks++; if (number !== EXP_NUMBER) begin n_fail++; $display("FAIL number_after_ops got %0d want %0d", number, EXP_NUMBER); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_basic;
    test_held_start;
    test_abort;
    test_back_to_back;
    test_number;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/square_calculator.md
Name: square_calculator

Overview:
- Iterative shift-add squarer; the inverse of the pipelined square-root unit.
- Takes a BW-bit root and returns the 2*BW-bit exact square after a fixed latency.
- Uses a start/busy/finish handshake.
- Built from the same primitives (FD2 registers, FA1 adders, MUX21H muxes, IV inverters) and reports its transistor count on `number`.
- Sits beside the sqrt unit for self-check: square(o_root) <= radicand < square(o_root+1).

Parameters:
- BW, 5, root width. Legal range 2..8. Result width is 2*BW. Iteration counter width is ceil(log2(BW)).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_root  in  BW  operand; latched on the accepted start edge
- o_busy  out  1  high in CALC and DONE
- o_finish  out  1  one-cycle pulse; o_square is valid and new
- o_square  out  2*BW  registered result; holds until the next DONE
- number  out  51  transistor count; combinational sum of all primitive instances

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; o_busy=0, o_finish=0, o_square=0.
  - Internal operand, multiplier, accumulator and counter all cleared.
- Release of rst takes effect at the next clk edge; no spurious o_finish.
- FSM states: IDLE, CALC, DONE.
- IDLE, edge with i_start=1:
  - opA <= zero-extended i_root (2*BW bits); mul <= i_root; acc <= 0; cnt <= 0.
  - state -> CALC.
- IDLE, edge with i_start=0: no state change.
- CALC, each edge:
  - acc <= acc + (mul[0] ? opA : 0); opA <= opA<<1; mul <= mul>>1; cnt <= cnt+1.
  - When cnt==BW-1: o_square <= acc + (mul[0] ? opA : 0) (the final sum), and state -> DONE.
- DONE: o_finish=1 for this cycle only. Next edge -> IDLE.
- Latency:
  - Start accepted at edge 0; iterations occur on edges 1..BW.
  - o_finish is high in the cycle after edge BW (BW=5: the 6th cycle after the accept edge).
  - IDLE is re-entered at edge BW+1. The next start can be accepted at edge BW+2 at the earliest.
- i_start while o_busy=1 (CALC or DONE): ignored; no queuing.
- i_root changes after the accept edge: no effect on the current operation.
- Arithmetic:
  - Unsigned only. Adder is 2*BW bits wide; carry-out is discarded.
  - Max result (2^BW-1)^2 < 2^(2*BW), so overflow is impossible.
- o_finish and o_busy are registered (decoded from state flops); no combinational path from i_start.
- o_square changes only on the edge entering DONE.
- rst asserted mid-CALC or in DONE: immediate abort; outputs go to reset values; no o_finish.
- number:
  - Constant for a given BW; equals the sum of all instantiated primitive counts (FD2, FA1, MUX21H, IV, plus FSM gates).
  - Must not depend on data or state.

Test Plan:
- Reset then i_start=1 with i_root=31 (BW=5) -> o_busy=1 from the next cycle; o_finish pulses exactly in cycle 6 with o_square=961; o_busy=0 from cycle 7.
- i_root=0 -> o_square=0 with o_finish in cycle 6. Then i_root=1 -> 1. Then i_root=16 -> 256.
- i_root=17 with i_start held high for 10 cycles -> one result of 289 (second start accepted at edge 7 yields a second 289 at cycle 13); i_root changed to 3 mid-CALC does not alter the 289.
- Start i_root=25, assert rst at cycle 3 -> o_busy, o_finish and o_square go to 0 immediately; no o_finish afterwards; new start with i_root=9 -> 81.
- Exhaustive 0..31, back-to-back at the minimum spacing -> each o_square equals root^2. Feed each square, and each square-1 for roots > 0, into the sqrt unit -> o_root equals root and root-1 respectively.
- Sample number at reset and after operations -> identical value, equal to the hand-computed primitive-count sum for BW=5.
